sobel_frame_ctrl: RTL and testbench



---
 rtl/sobel_frame_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer around the Sobel filter chain: passes one gray frame in,
// injects flush pixels to drain the line buffers, drops the warm-up returns
// and tags the remaining one-per-input output pixels with SOF/EOL/EOF.
module sobel_frame_ctrl #(
   parameter int unsigned WIDTH_P     = 8,
   parameter int unsigned LINE_W_P    = 640,
   parameter int unsigned FRAME_H_P   = 480,
   parameter int unsigned LAT_LINES_P = 2,
   parameter int unsigned LAT_PIX_P   = 2,
   parameter int unsigned FLUSH_VAL_P = 0
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [WIDTH_P-1:0] data_i,
   output logic               pipe_valid_o,
   input  logic               pipe_ready_i,
   output logic [WIDTH_P-1:0] pipe_data_o,
   input  logic               ret_valid_i,
   output logic               ret_ready_o,
   input  logic [WIDTH_P-1:0] ret_data_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [WIDTH_P-1:0] data_o,
   output logic               sof_o,
   output logic               eol_o,
   output logic               eof_o,
   output logic               busy_o,
   output logic               frame_done_o
);

   localparam int unsigned N_LP    = LINE_W_P * FRAME_H_P;
   localparam int unsigned L_LP    = LAT_LINES_P * LINE_W_P + LAT_PIX_P;
   localparam int unsigned IN_W_LP = (N_LP > 1) ? $clog2(N_LP) : 1;
   localparam int unsigned L_W_LP  = (L_LP > 1) ? $clog2(L_LP) : 1;
   localparam int unsigned X_W_LP  = (LINE_W_P > 1) ? $clog2(LINE_W_P) : 1;
   localparam int unsigned Y_W_LP  = (FRAME_H_P > 1) ? $clog2(FRAME_H_P) : 1;

   localparam logic [IN_W_LP-1:0] IN_LAST_LP = IN_W_LP'(N_LP - 1);
   localparam logic [L_W_LP-1:0]  L_LAST_LP  = L_W_LP'(L_LP - 1);
   localparam logic [X_W_LP-1:0]  X_LAST_LP  = X_W_LP'(LINE_W_P - 1);
   localparam logic [Y_W_LP-1:0]  Y_LAST_LP  = Y_W_LP'(FRAME_H_P - 1);
   localparam logic [WIDTH_P-1:0] FLUSH_LP   = WIDTH_P'(FLUSH_VAL_P);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_WAIT   = 2'd3
   } state_e;

   state_e              state_q,    state_d;
   logic [IN_W_LP-1:0]  in_cnt_q,   in_cnt_d;
   logic [L_W_LP-1:0]   fl_cnt_q,   fl_cnt_d;
   logic [L_W_LP-1:0]   dis_cnt_q,  dis_cnt_d;
   logic                dis_done_q, dis_done_d;
   logic [X_W_LP-1:0]   out_x_q,    out_x_d;
   logic [Y_W_LP-1:0]   out_y_q,    out_y_d;

   logic in_hs_s, pipe_hs_s, ret_hs_s, out_hs_s, last_beat_s;

   assign in_hs_s     = valid_i & ready_o;
   assign pipe_hs_s   = pipe_valid_o & pipe_ready_i;
   assign ret_hs_s    = ret_valid_i & ret_ready_o;
   assign out_hs_s    = valid_o & ready_i;
   assign last_beat_s = out_hs_s & eof_o;
   assign busy_o       = (state_q != ST_IDLE);
   assign frame_done_o = (state_q == ST_WAIT) & last_beat_s;

   // Input side: pass-through while streaming, flush pixels while draining, closed while waiting.
   always_comb begin
      ready_o      = 1'b0;
      pipe_valid_o = 1'b0;
      pipe_data_o  = data_i;
      case (state_q)
         ST_IDLE, ST_STREAM: begin
            ready_o      = pipe_ready_i;
            pipe_valid_o = valid_i;
            pipe_data_o  = data_i;
         end
         ST_FLUSH: begin
            ready_o      = 1'b0;
            pipe_valid_o = 1'b1;
            pipe_data_o  = FLUSH_LP;
         end
         ST_WAIT: begin
            ready_o      = 1'b0;
            pipe_valid_o = 1'b0;
            pipe_data_o  = data_i;
         end
         default: begin
            ready_o      = 1'b0;
            pipe_valid_o = 1'b0;
            pipe_data_o  = data_i;
         end
      endcase
   end

   // Return side: swallow the warm-up samples, then forward with position tags.
   always_comb begin
      ret_ready_o = 1'b1;
      valid_o     = 1'b0;
      data_o      = ret_data_i;
      sof_o       = (out_x_q == X_W_LP'(0)) && (out_y_q == Y_W_LP'(0));
      eol_o       = (out_x_q == X_LAST_LP);
      eof_o       = (out_x_q == X_LAST_LP) && (out_y_q == Y_LAST_LP);
      if (dis_done_q) begin
         valid_o     = ret_valid_i;
         ret_ready_o = ready_i;
      end else begin
         valid_o     = 1'b0;
         ret_ready_o = 1'b1;
      end
   end

   // Next-state for the frame FSM and all counters; everything moves only on handshakes.
   always_comb begin
      state_d    = state_q;
      in_cnt_d   = in_cnt_q;
      fl_cnt_d   = fl_cnt_q;
      dis_cnt_d  = dis_cnt_q;
      dis_done_d = dis_done_q;
      out_x_d    = out_x_q;
      out_y_d    = out_y_q;

      case (state_q)
         ST_IDLE, ST_STREAM: begin
            if (in_hs_s) begin
               if (in_cnt_q == IN_LAST_LP) begin
                  in_cnt_d = IN_W_LP'(0);
                  state_d  = ST_FLUSH;
               end else begin
                  in_cnt_d = in_cnt_q + IN_W_LP'(1);
                  state_d  = ST_STREAM;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_FLUSH: begin
            if (pipe_hs_s) begin
               if (fl_cnt_q == L_LAST_LP) begin
                  fl_cnt_d = L_W_LP'(0);
                  state_d  = ST_WAIT;
               end else begin
                  fl_cnt_d = fl_cnt_q + L_W_LP'(1);
                  state_d  = ST_FLUSH;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_WAIT: begin
            if (last_beat_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Warm-up discard is independent of the input-side state.
      if (ret_hs_s && !dis_done_q) begin
         if (dis_cnt_q == L_LAST_LP) begin
            dis_cnt_d  = L_W_LP'(0);
            dis_done_d = 1'b1;
         end else begin
            dis_cnt_d  = dis_cnt_q + L_W_LP'(1);
            dis_done_d = dis_done_q;
         end
      end else if ((state_q == ST_WAIT) && last_beat_s) begin
         dis_cnt_d  = dis_cnt_q;
         dis_done_d = 1'b0;
      end else begin
         dis_cnt_d  = dis_cnt_q;
         dis_done_d = dis_done_q;
      end

      if (out_hs_s) begin
         if (out_x_q == X_LAST_LP) begin
            out_x_d = X_W_LP'(0);
            out_y_d = (out_y_q == Y_LAST_LP) ? Y_W_LP'(0) : (out_y_q + Y_W_LP'(1));
         end else begin
            out_x_d = out_x_q + X_W_LP'(1);
            out_y_d = out_y_q;
         end
      end else begin
         out_x_d = out_x_q;
         out_y_d = out_y_q;
      end
   end

   // State and counter registers; reset abandons any partial frame.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= ST_IDLE;
         in_cnt_q   <= IN_W_LP'(0);
         fl_cnt_q   <= L_W_LP'(0);
         dis_cnt_q  <= L_W_LP'(0);
         dis_done_q <= 1'b0;
         out_x_q    <= X_W_LP'(0);
         out_y_q    <= Y_W_LP'(0);
      end else begin
         state_q    <= state_d;
         in_cnt_q   <= in_cnt_d;
         fl_cnt_q   <= fl_cnt_d;
         dis_cnt_q  <= dis_cnt_d;
         dis_done_q <= dis_done_d;
         out_x_q    <= out_x_d;
         out_y_q    <= out_y_d;
      end
   end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: two instances (L=5 and L=1), each wrapped by a
// queue-based stand-in filter chain that returns every injected sample delayed
// by L samples. Expected output is the frame's own pixels with positional tags.
module tb_sobel_frame_ctrl;

   localparam int LW = 4;
   localparam int FH = 3;
   localparam int N  = LW * FH;
   localparam int LA = 5;
   localparam int LB = 1;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic       vi[2], rdo[2], pvo[2], pri[2], rvi[2], rro[2], vo[2], ri[2];
   logic       sof[2], eol[2], eof[2], busy[2], fdone[2];
   logic [7:0] di[2], pdo[2], rdi[2], dout[2];

   int checks = 0;
   int errors = 0;

   logic [7:0] pix[N];
   logic [7:0] dl0[$], dl1[$], oq0[$], oq1[$];

   sobel_frame_ctrl #(.WIDTH_P(8), .LINE_W_P(LW), .FRAME_H_P(FH),
                      .LAT_LINES_P(1), .LAT_PIX_P(1), .FLUSH_VAL_P(0)) u0 (
      .clk_i(clk), .rstn_i(rstn),
      .valid_i(vi[0]), .ready_o(rdo[0]), .data_i(di[0]),
      .pipe_valid_o(pvo[0]), .pipe_ready_i(pri[0]), .pipe_data_o(pdo[0]),
      .ret_valid_i(rvi[0]), .ret_ready_o(rro[0]), .ret_data_i(rdi[0]),
      .valid_o(vo[0]), .ready_i(ri[0]), .data_o(dout[0]),
      .sof_o(sof[0]), .eol_o(eol[0]), .eof_o(eof[0]),
      .busy_o(busy[0]), .frame_done_o(fdone[0]));

   sobel_frame_ctrl #(.WIDTH_P(8), .LINE_W_P(LW), .FRAME_H_P(FH),
                      .LAT_LINES_P(0), .LAT_PIX_P(1), .FLUSH_VAL_P(0)) u1 (
      .clk_i(clk), .rstn_i(rstn),
      .valid_i(vi[1]), .ready_o(rdo[1]), .data_i(di[1]),
      .pipe_valid_o(pvo[1]), .pipe_ready_i(pri[1]), .pipe_data_o(pdo[1]),
      .ret_valid_i(rvi[1]), .ret_ready_o(rro[1]), .ret_data_i(rdi[1]),
      .valid_o(vo[1]), .ready_i(ri[1]), .data_o(dout[1]),
      .sof_o(sof[1]), .eol_o(eol[1]), .eof_o(eof[1]),
      .busy_o(busy[1]), .frame_done_o(fdone[1]));

   function automatic int lat(input int d);
      return (d == 0) ? LA : LB;
   endfunction

   function automatic int oq_size(input int d);
      return (d == 0) ? oq0.size() : oq1.size();
   endfunction

   function automatic logic [7:0] oq_head(input int d);
      if (d == 0) return oq0[0];
      return oq1[0];
   endfunction

   // Stand-in chain reset: empty return queue, delay line full of warm-up garbage.
   task automatic chain_init(input int d);
      if (d == 0) begin
         oq0.delete(); dl0.delete();
         for (int i = 0; i < LA; i++) dl0.push_back(8'(8'hA0 + i));
      end else begin
         oq1.delete(); dl1.delete();
         for (int i = 0; i < LB; i++) dl1.push_back(8'(8'hC0 + i));
      end
   endtask

   task automatic chain_push(input int d, input logic [7:0] v);
      if (d == 0) begin oq0.push_back(dl0.pop_front()); dl0.push_back(v); end
      else begin oq1.push_back(dl1.pop_front()); dl1.push_back(v); end
   endtask

   task automatic chain_pop(input int d);
      if (d == 0) void'(oq0.pop_front());
      else void'(oq1.pop_front());
   endtask

   task automatic idle_inputs();
      for (int d = 0; d < 2; d++) begin
         vi[d] = 1'b0; di[d] = 8'h00; pri[d] = 1'b1;
         rvi[d] = 1'b0; rdi[d] = 8'h00; ri[d] = 1'b0;
      end
   endtask

   // Runs one frame on instance d (entered and left just after a negedge).
   // vgap: % of cycles valid_i is withheld; rdy/pr: % ready_i / chain-ready;
   // b2b: hold valid_i high after the last pixel; abort_at: stop after that many inputs;
   // disc_hold: cycles to keep ready_i low once the first forward sample is pending.
   task automatic run_frame(input int d, input int vgap, input int rdy, input int pr,
                            input bit b2b, input int abort_at, input int disc_hold);
      int in_acc, fl, ret_n, out_k, cyc, hold_cnt, L;
      bit done, aborted, first, pst;
      logic in_hs, pipe_hs, ret_hs, out_hs, is_fl;
      logic [7:0] pv, pdat;
      logic ps, pe, pf;
      in_acc = 0; fl = 0; ret_n = 0; out_k = 0; cyc = 0; hold_cnt = 0;
      done = 1'b0; aborted = 1'b0; first = 1'b1; pst = 1'b0;
      pdat = 8'h00; ps = 1'b0; pe = 1'b0; pf = 1'b0;
      L = lat(d);
      while (!done && cyc < 3000) begin
         if (in_acc < N) begin
            vi[d] = b2b ? 1'b1 : ($urandom_range(99) >= vgap);
            di[d] = pix[in_acc];
         end else begin
            vi[d] = b2b;
            di[d] = pix[0];
         end
         if (disc_hold > 0 && hold_cnt < disc_hold) ri[d] = 1'b0;
         else ri[d] = ($urandom_range(99) < rdy);
         pri[d] = (oq_size(d) < 2) && ($urandom_range(99) < pr);
         rvi[d] = (oq_size(d) > 0);
         rdi[d] = rvi[d] ? oq_head(d) : 8'h00;
         #2;
         if (first) begin
            checks++;
            if (rdo[d] !== pri[d]) begin
               errors++; $display("FAIL first_ready d=%0d ready_o=%b expected=%b", d, rdo[d], pri[d]);
            end
            first = 1'b0;
         end
         if (in_acc > 0) begin
            checks++;
            if (busy[d] !== 1'b1) begin
               errors++; $display("FAIL busy_high d=%0d busy_o=%b expected=1", d, busy[d]);
            end
         end
         checks++;
         if (in_acc < N) begin
            if (pvo[d] !== vi[d] || (vi[d] && pdo[d] !== di[d]) || rdo[d] !== pri[d]) begin
               errors++; $display("FAIL passthru d=%0d pipe_valid=%b pipe_data=%h ready=%b expected %b %h %b",
                                  d, pvo[d], pdo[d], rdo[d], vi[d], di[d], pri[d]);
            end
         end else if (fl < L) begin
            if (rdo[d] !== 1'b0 || pvo[d] !== 1'b1 || pdo[d] !== 8'h00) begin
               errors++; $display("FAIL flush_beat d=%0d ready=%b pipe_valid=%b pipe_data=%h expected 0 1 00",
                                  d, rdo[d], pvo[d], pdo[d]);
            end
         end else begin
            if (rdo[d] !== 1'b0 || pvo[d] !== 1'b0) begin
               errors++; $display("FAIL wait_closed d=%0d ready=%b pipe_valid=%b expected 0 0", d, rdo[d], pvo[d]);
            end
         end
         checks++;
         if (ret_n < L) begin
            if (vo[d] !== 1'b0 || rro[d] !== 1'b1) begin
               errors++; $display("FAIL discard d=%0d valid_o=%b ret_ready=%b expected 0 1", d, vo[d], rro[d]);
            end
         end else begin
            if (vo[d] !== rvi[d] || (rvi[d] && rro[d] !== ri[d])) begin
               errors++; $display("FAIL forward d=%0d valid_o=%b ret_ready=%b expected %b %b",
                                  d, vo[d], rro[d], rvi[d], ri[d]);
            end
            if (disc_hold > 0 && hold_cnt < disc_hold && rvi[d]) begin
               checks++;
               if (rro[d] !== 1'b0 || vo[d] !== 1'b1) begin
                  errors++; $display("FAIL held_first d=%0d ret_ready=%b valid_o=%b expected 0 1", d, rro[d], vo[d]);
               end
               hold_cnt++;
            end
         end
         if (pst && vo[d] === 1'b1) begin
            checks++;
            if (dout[d] !== pdat || sof[d] !== ps || eol[d] !== pe || eof[d] !== pf) begin
               errors++; $display("FAIL out_stable d=%0d data=%h tags=%b%b%b expected %h %b%b%b",
                                  d, dout[d], sof[d], eol[d], eof[d], pdat, ps, pe, pf);
            end
         end
         out_hs = vo[d] & ri[d];
         if (out_hs === 1'b1) begin
            checks++;
            if (dout[d] !== pix[out_k] || sof[d] !== (out_k == 0) ||
                eol[d] !== (out_k % LW == LW - 1) || eof[d] !== (out_k == N - 1)) begin
               errors++; $display("FAIL out_beat d=%0d k=%0d data=%h sof=%b eol=%b eof=%b expected %h %b %b %b",
                                  d, out_k, dout[d], sof[d], eol[d], eof[d], pix[out_k],
                                  (out_k == 0), (out_k % LW == LW - 1), (out_k == N - 1));
            end
         end
         checks++;
         if (fdone[d] !== ((out_hs === 1'b1) && out_k == N - 1)) begin
            errors++; $display("FAIL frame_done d=%0d k=%0d frame_done_o=%b", d, out_k, fdone[d]);
         end
         in_hs = vi[d] & rdo[d];
         pipe_hs = pvo[d] & pri[d];
         ret_hs = rvi[d] & rro[d];
         pv = pdo[d];
         is_fl = (in_acc >= N);
         pst = vo[d] & ~ri[d];
         pdat = dout[d]; ps = sof[d]; pe = eol[d]; pf = eof[d];
         @(posedge clk);
         if (pipe_hs === 1'b1) begin
            chain_push(d, pv);
            if (is_fl) fl++;
         end
         if (ret_hs === 1'b1) begin
            chain_pop(d);
            ret_n++;
         end
         if (out_hs === 1'b1) begin
            out_k++;
            if (out_k == N) done = 1'b1;
         end
         if (in_hs === 1'b1) begin
            in_acc++;
            if (abort_at > 0 && in_acc == abort_at) begin
               done = 1'b1; aborted = 1'b1;
            end
         end
         cyc++;
         #1;
         if (done && !aborted) begin
            checks++;
            if (busy[d] !== 1'b0) begin
               errors++; $display("FAIL busy_drop d=%0d busy_o=%b expected 0", d, busy[d]);
            end
         end
         @(negedge clk);
      end
      if (!done) begin
         errors++; $display("FAIL timeout d=%0d in=%0d flush=%0d out=%0d", d, in_acc, fl, out_k);
      end
      if (!aborted) begin
         checks++;
         if (fl != L || out_k != N || ret_n != N + L) begin
            errors++; $display("FAIL counts d=%0d flush=%0d out=%0d ret=%0d expected %0d %0d %0d",
                               d, fl, out_k, ret_n, L, N, N + L);
         end
      end
   endtask

   task automatic set_pix(input bit seq);
      for (int i = 0; i < N; i++) pix[i] = seq ? 8'(i + 1) : 8'($urandom_range(255));
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      idle_inputs();
      chain_init(0); chain_init(1);
      #2;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (busy[d] !== 1'b0 || fdone[d] !== 1'b0 || pvo[d] !== 1'b0 || vo[d] !== 1'b0 ||
             rdo[d] !== 1'b1 || rro[d] !== 1'b1 || sof[d] !== 1'b1) begin
            errors++; $display("FAIL reset d=%0d busy=%b done=%b pvalid=%b valid=%b ready=%b rready=%b sof=%b",
                               d, busy[d], fdone[d], pvo[d], vo[d], rdo[d], rro[d], sof[d]);
         end
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_full_frame();
      set_pix(1'b1);
      run_frame(0, 0, 100, 100, 1'b0, 0, 0);
   endtask

   task automatic test_random_stalls();
      set_pix(1'b1);
      run_frame(0, 30, 50, 60, 1'b0, 0, 0);
      set_pix(1'b0);
      run_frame(0, 40, 50, 50, 1'b0, 0, 0);
   endtask

   task automatic test_back_to_back();
      set_pix(1'b0);
      run_frame(0, 0, 70, 80, 1'b1, 0, 0);
      set_pix(1'b0);
      run_frame(0, 0, 70, 80, 1'b1, 0, 0);
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      set_pix(1'b0);
      run_frame(0, 10, 80, 90, 1'b0, 7, 0);
      rstn = 1'b0;
      idle_inputs();
      chain_init(0); chain_init(1);
      #2;
      checks++;
      if (busy[0] !== 1'b0 || fdone[0] !== 1'b0 || pvo[0] !== 1'b0 || vo[0] !== 1'b0 ||
          rdo[0] !== 1'b1 || rro[0] !== 1'b1) begin
         errors++; $display("FAIL reset_mid busy=%b done=%b pvalid=%b valid=%b ready=%b rready=%b",
                            busy[0], fdone[0], pvo[0], vo[0], rdo[0], rro[0]);
      end
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      set_pix(1'b0);
      run_frame(0, 20, 70, 80, 1'b0, 0, 0);
   endtask

   task automatic test_discard_hold();
      set_pix(1'b0);
      run_frame(0, 0, 100, 100, 1'b0, 0, 3);
   endtask

   task automatic test_lat1();
      set_pix(1'b1);
      run_frame(1, 0, 100, 100, 1'b0, 0, 0);
      set_pix(1'b0);
      run_frame(1, 30, 50, 60, 1'b0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_random_stalls();
      test_back_to_back();
      test_reset_mid();
      test_discard_hold();
      test_lat1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
